multdiv_seq: RTL

//  Multi-cycle signed 32-bit multiply/divide unit that runs alongside the single-cycle ALU in the

---
 rtl/multdiv_seq_pkg.sv | 20 ++
 rtl/multdiv_seq_cla32.sv | 57 +++++
 rtl/multdiv_seq.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_seq_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_seq_pkg
// Shared definitions for the multi-cycle multiply/divide unit: datapath width,
// step-counter width and the FSM state encoding (IDLE/MUL/DIV/DONE, 2 bits).
// No ports; imported by multdiv_seq.
// -----------------------------------------------------------------------------
package multdiv_seq_pkg;

    localparam int MULTDIV_WIDTH = 32;
    // Wide enough to hold the saturated value MULTDIV_WIDTH.
    localparam int CNT_W         = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : multdiv_seq_pkg

// File: rtl/multdiv_seq_cla32.sv
// -----------------------------------------------------------------------------
// cla32
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups whose group
// generate/propagate terms produce the inter-group carries.
// Ports:
//   a, b  in  32  addends
//   cin   in  1   carry in
//   sum   out 32  a + b + cin (mod 2^32)
//   cout  out 1   carry out of bit 31
// -----------------------------------------------------------------------------
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic [3:0] gs;
        logic [3:0] ps;
        logic       ci;
        logic       grp_g;
        logic       grp_p;
        c     = '0;
        gs    = '0;
        ps    = '0;
        ci    = 1'b0;
        grp_g = 1'b0;
        grp_p = 1'b0;
        c[0]  = cin;
        for (int k = 0; k < 8; k++) begin
            gs = g[4*k +: 4];
            ps = p[4*k +: 4];
            ci = c[4*k];
            c[4*k+1] = gs[0] | (ps[0] & ci);
            c[4*k+2] = gs[1] | (ps[1] & gs[0]) | (ps[1] & ps[0] & ci);
            c[4*k+3] = gs[2] | (ps[2] & gs[1]) | (ps[2] & ps[1] & gs[0])
                     | (ps[2] & ps[1] & ps[0] & ci);
            grp_g    = gs[3] | (ps[3] & gs[2]) | (ps[3] & ps[2] & gs[1])
                     | (ps[3] & ps[2] & ps[1] & gs[0]);
            grp_p    = &ps;
            c[4*k+4] = grp_g | (grp_p & ci);
        end
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];

endmodule : cla32

// File: rtl/multdiv_seq.sv
// -----------------------------------------------------------------------------
// multdiv_seq
// Multi-cycle signed multiply / divide unit. A one-cycle ctrl_MULT or ctrl_DIV
// pulse captures the operands and starts a WIDTH-step iteration (radix-2 Booth
// for multiply, restoring division on magnitudes for divide); completion is a
// one-cycle data_resultRDY pulse. A start pulse in any state restarts the unit.
// Optional feature macro: MULTDIV_REMAINDER_EN adds the data_remainder output.
// Ports:
//   clock           in   1      rising-edge clock
//   reset           in   1      synchronous, active-high
//   data_operandA   in   WIDTH  multiplicand / dividend (two's complement)
//   data_operandB   in   WIDTH  multiplier / divisor (two's complement)
//   ctrl_MULT       in   1      start multiply (wins over ctrl_DIV)
//   ctrl_DIV        in   1      start divide
//   data_result     out  WIDTH  low half of product, or quotient
//   data_exception  out  1      overflow / divide-by-zero, valid with RDY
//   data_resultRDY  out  1      one-cycle completion pulse
//   data_busy       out  1      high while iterating (MUL/DIV states)
//   data_remainder  out  WIDTH  signed remainder (MULTDIV_REMAINDER_EN only)
// -----------------------------------------------------------------------------
module multdiv_seq
    import multdiv_seq_pkg::*;
#(
    // Both cla32 instances are fixed at 32 bits, so this must stay 32.
    parameter int WIDTH = MULTDIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             data_busy
`ifdef MULTDIV_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] data_remainder
`endif
);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             last_step;

    // acc:lo:extra form the 2*WIDTH+1 Booth product register. For divide, acc
    // is the partial remainder and lo shifts the dividend out / quotient in.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lo;
    logic             extra;
    logic [WIDTH-1:0] opnd;      // multiplicand, or raw signed divisor
    logic             is_div;
    logic             sign_a;
    logic             sign_b;
    logic             div_by_zero;

    logic             start;
    logic             div_zero;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    logic [WIDTH-1:0] neg_in;
    logic [WIDTH-1:0] neg_sum;
    logic             neg_cout;

    logic             booth_msb;
    logic [WIDTH-1:0] div_shift;
    logic [WIDTH:0]   prod_hi;
    logic             mul_ovf;
    logic             quo_neg;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign last_step = (count == CNT_W'(WIDTH - 1));
    assign count_inc = (count == CNT_W'(WIDTH)) ? count : count + 1'b1;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples pre-edge values regardless of block ordering.
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        state_nx  = state;
        data_busy = (state == ST_MUL) || (state == ST_DIV);
        if (start) begin
            state_nx = ctrl_MULT ? ST_MUL : ST_DIV;
        end else begin
            case (state)
                ST_IDLE: state_nx = ST_IDLE;
                ST_MUL:  if (last_step) state_nx = ST_DONE;
                ST_DIV:  if (div_zero || last_step) state_nx = ST_DONE;
                ST_DONE: state_nx = ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------- sign/magnitude negator
    // Computes 0 - neg_in. On a start it yields |A| for the dividend; while in
    // DIV it is fed the divisor, whose carry-out flags B == 0; in DONE it
    // negates the quotient magnitude.
    always_comb begin
        neg_in = lo;
        if (start)               neg_in = data_operandA;
        else if (state == ST_DIV) neg_in = opnd;
    end

    cla32 u_negate (
        .a    ('0),
        .b    (~neg_in),
        .cin  (1'b1),
        .sum  (neg_sum),
        .cout (neg_cout)
    );

    assign div_zero = (state == ST_DIV) && !start && neg_cout;

    // ------------------------------------------------ shared iteration adder
    assign div_shift = {acc[WIDTH-2:0], lo[WIDTH-1]};

    always_comb begin
        add_a   = acc;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            ST_MUL: begin
                case ({lo[0], extra})
                    2'b01:   add_b = opnd;
                    2'b10: begin
                        add_b   = ~opnd;
                        add_cin = 1'b1;
                    end
                    default: add_b = '0;
                endcase
            end
            ST_DIV: begin
                // Subtract |B| without forming it: a negative divisor is added
                // as-is, a positive one is subtracted. Carry-out means no borrow.
                add_a   = div_shift;
                add_b   = opnd[WIDTH-1] ? opnd : ~opnd;
                add_cin = ~opnd[WIDTH-1];
            end
`ifdef MULTDIV_REMAINDER_EN
            ST_DONE: begin
                // Idle adder negates the remainder magnitude.
                add_a   = '0;
                add_b   = ~acc;
                add_cin = 1'b1;
            end
`endif
            default: add_cin = 1'b0;
        endcase
    end

    cla32 u_iter_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Sign of the true WIDTH+1-bit Booth sum; keeps the arithmetic shift exact
    // even when subtracting the most negative multiplicand overflows WIDTH bits.
    assign booth_msb = acc[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout;

    // Product fits WIDTH bits only if bits [2W-1:W-1] are all equal.
    assign prod_hi = {acc, lo[WIDTH-1]};
    assign mul_ovf = !((&prod_hi) || !(|prod_hi));
    assign quo_neg = sign_a ^ sign_b;

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clock) begin
        // NOTE: the whole datapath is reset, not just the visible outputs, so
        // no X from an uninitialised register can reach data_result.
        if (reset) begin
            count          <= '0;
            acc            <= '0;
            lo             <= '0;
            extra          <= 1'b0;
            opnd           <= '0;
            is_div         <= 1'b0;
            sign_a         <= 1'b0;
            sign_b         <= 1'b0;
            div_by_zero    <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
            data_remainder <= '0;
`endif
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                count          <= '0;
                acc            <= '0;
                extra          <= 1'b0;
                div_by_zero    <= 1'b0;
                data_exception <= 1'b0;
                is_div         <= ~ctrl_MULT;
                sign_a         <= data_operandA[WIDTH-1];
                sign_b         <= data_operandB[WIDTH-1];
                if (ctrl_MULT) begin
                    opnd <= data_operandA;
                    lo   <= data_operandB;
                end else begin
                    opnd <= data_operandB;
                    lo   <= data_operandA[WIDTH-1] ? neg_sum : data_operandA;
                end
            end else begin
                case (state)
                    ST_MUL: begin
                        acc   <= {booth_msb, add_sum[WIDTH-1:1]};
                        lo    <= {add_sum[0], lo[WIDTH-1:1]};
                        extra <= lo[0];
                        count <= count_inc;
                    end
                    ST_DIV: begin
                        if (div_zero) begin
                            div_by_zero <= 1'b1;
                        end else begin
                            acc   <= add_cout ? add_sum : div_shift;
                            lo    <= {lo[WIDTH-2:0], add_cout};
                            count <= count_inc;
                        end
                    end
                    ST_DONE: begin
                        data_resultRDY <= 1'b1;
                        if (!is_div) begin
                            data_result    <= lo;
                            data_exception <= mul_ovf;
`ifdef MULTDIV_REMAINDER_EN
                            data_remainder <= '0;
`endif
                        end else if (div_by_zero) begin
                            data_result    <= '0;
                            data_exception <= 1'b1;
`ifdef MULTDIV_REMAINDER_EN
                            data_remainder <= '0;
`endif
                        end else begin
                            data_result    <= quo_neg ? neg_sum : lo;
                            // A positive quotient with the top bit set only
                            // arises from MIN / -1.
                            data_exception <= lo[WIDTH-1] & ~quo_neg;
`ifdef MULTDIV_REMAINDER_EN
                            data_remainder <= sign_a ? add_sum : acc;
`endif
                        end
                    end
                    default: count <= count;
                endcase
            end
        end
    end

endmodule : multdiv_seq
